spi_bus_arbiter: RTL

Shares the single `master_spi_controller` between two SPI clients: client 0 is the display controller, client 1 is a second peripheral such as a touch or flash controller. Each client claims the bus for a whole multi-byte transaction. The arbiter grants one owner at a time, drives a dedicated active-low chip select per device, and routes start, data and busy between the owner and the SPI controller. It enforces a minimum deselect gap between owners and can pre-empt an owner that holds the bus idle.

---
 rtl/spi_bus_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI controller between two clients.
// Owns the bus per transaction, drives per-device chip selects, enforces a
// deselect gap between owners and optionally pre-empts an idle owner.
module spi_bus_arbiter #(
    parameter int unsigned CS_GAP_CYCLES = 2,
    parameter int unsigned IDLE_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       start0,
    input  logic       start1,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    output logic       busy0,
    output logic       busy1,
    output logic [7:0] data_out,
    output logic       spi_start,
    output logic [7:0] spi_data_in,
    input  logic [7:0] spi_data_out,
    input  logic       spi_busy,
    output logic [1:0] cs_n,
    output logic       preempt
);

    typedef enum logic [1:0] {StIdle, StOwn, StDrain, StGap} state_e;

    // Gap counter counts down to zero, so it is preloaded one short.
    localparam logic [7:0]  GapLoad   = 8'(CS_GAP_CYCLES - 1);
    localparam logic [15:0] IdleTo    = 16'(IDLE_TIMEOUT);
    localparam bit          PreemptEn = (IDLE_TIMEOUT != 0);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_owner;
    logic        w_owner_d;
    logic        r_last_owner;
    logic [1:0]  r_gnt;
    logic [1:0]  r_cs_n;
    logic [1:0]  r_block;
    logic [1:0]  w_block_d;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_idle_cnt;

    logic [1:0]  w_req;
    logic [1:0]  w_req_eff;
    logic        w_own_req;
    logic        w_own_start;
    logic        w_other_req;
    logic        w_timeout;
    logic        w_release;

    // A pre-empted client stays blocked until it drops its request.
    assign w_req       = {req1, req0};
    assign w_req_eff   = w_req & ~r_block;
    assign w_own_req   = w_req[r_owner];
    assign w_own_start = (r_owner ? start1 : start0) & w_own_req;
    assign w_other_req = w_req_eff[~r_owner];
    assign w_timeout   = PreemptEn && (r_state == StOwn) && (r_idle_cnt == IdleTo);
    assign w_release   = (r_state == StOwn) && (!w_own_req || w_timeout);
    assign w_block_d   = (r_block | ({2{w_timeout}} & (r_owner ? 2'b10 : 2'b01))) & w_req;

    // State and owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
        end
    end

    // Next-state and owner selection.
    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        case (r_state)
            StIdle: begin
                if (|w_req_eff) begin
                    w_state_d = StOwn;
                    // On a tie the client that did not own the bus last wins.
                    if (&w_req_eff) begin
                        w_owner_d = ~r_last_owner;
                    end else begin
                        w_owner_d = w_req_eff[1];
                    end
                end
            end
            StOwn: begin
                if (w_release) begin
                    w_state_d = spi_busy ? StDrain : StGap;
                end
            end
            StDrain: begin
                if (!spi_busy) begin
                    w_state_d = StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Routing of start, data and busy between owner and controller.
    always_comb begin
        spi_start   = (r_state == StOwn) && w_own_start && !w_timeout;
        spi_data_in = r_owner ? data_in1 : data_in0;
        data_out    = spi_data_out;
        preempt     = w_timeout;
        busy0       = 1'b1;
        busy1       = 1'b1;
        if (r_state == StOwn) begin
            if (r_owner) begin
                busy1 = spi_busy;
            end else begin
                busy0 = spi_busy;
            end
        end
    end

    // Registered grants/chip selects, gap and idle counters, fairness state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= 2'b00;
            r_cs_n       <= 2'b11;
            r_last_owner <= 1'b1;
            r_gap_cnt    <= 8'd0;
            r_idle_cnt   <= 16'd0;
            r_block      <= 2'b00;
        end else begin
            r_gnt  <= (w_state_d == StOwn) ? (w_owner_d ? 2'b10 : 2'b01) : 2'b00;
            r_cs_n <= ((w_state_d == StOwn) || (w_state_d == StDrain)) ?
                      (w_owner_d ? 2'b01 : 2'b10) : 2'b11;

            if (r_state != StGap) begin
                r_gap_cnt <= GapLoad;
            end else if (r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end

            if ((r_state == StGap) && (w_state_d == StIdle)) begin
                r_last_owner <= r_owner;
            end

            // Counts only idle cycles where the other client is kept waiting.
            if (!PreemptEn || (r_state != StOwn) || w_release || w_own_start || !w_other_req) begin
                r_idle_cnt <= 16'd0;
            end else if (!spi_busy) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end

            r_block <= w_block_d;
        end
    end

    assign gnt0 = r_gnt[0];
    assign gnt1 = r_gnt[1];
    assign cs_n = r_cs_n;

endmodule
